// File: rtl/program_loader.sv
// program_loader: streams a program into instruction RAM, runs the core for a set
// number of cycles, drains, then dumps the register file under valid/ready.
module program_loader #(
  parameter int ADDR_W       = 9,
  parameter int RUN_W        = 16,
  parameter int DRAIN_CYCLES = 4,
  parameter int RD_LAT       = 1,
  parameter int NREG         = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  input  logic [RUN_W-1:0]  run_cycles,
  output logic [ADDR_W-1:0] core_addr,
  output logic              core_wen,
  output logic [31:0]       core_wdat,
  output logic              core_working,
  output logic [3:0]        core_rid,
  input  logic [31:0]       core_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [3:0]        out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              load_full,
  output logic              done
);
  localparam int DW = DRAIN_CYCLES > 0 ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam int LW = RD_LAT > 0 ? $clog2(RD_LAT + 1) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DUMP, DONE} state_t;
  state_t state, next;

  logic [ADDR_W-1:0] count, wr_addr;
  logic [RUN_W-1:0]  run_cnt;
  logic [DW-1:0]     drain_cnt;
  logic [LW-1:0]     lat_cnt;
  logic              acc_in, acc_out, last_word, last_idx;

  assign acc_in    = in_ready & in_valid;
  assign acc_out   = out_valid & out_ready;
  assign wr_addr   = state == IDLE ? '0 : count;
  assign last_word = in_last | (wr_addr == '1);
  assign last_idx  = core_rid == 4'(NREG - 1);

  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= next;

  always_comb begin
    next = state;
    case (state)
      IDLE, LOAD: if (acc_in) next = last_word ? RUN : LOAD;
      RUN:        if (run_cnt == '0) next = DRAIN;
      DRAIN:      if (drain_cnt == DW'(DRAIN_CYCLES - 1)) next = DUMP;
      DUMP:       if (acc_out && last_idx) next = DONE;
      default:    next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = state == IDLE || state == LOAD;
    busy     = state != IDLE;
    done     = state == DONE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      core_addr    <= '0;
      core_wen     <= 1'b0;
      core_wdat    <= '0;
      core_working <= 1'b0;
      core_rid     <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_idx      <= '0;
      out_last     <= 1'b0;
      load_full    <= 1'b0;
      count        <= '0;
      run_cnt      <= '0;
      drain_cnt    <= '0;
      lat_cnt      <= '0;
    end else begin
      core_wen     <= acc_in;
      core_working <= state == RUN && run_cnt != '0;
      drain_cnt    <= state == DRAIN ? drain_cnt + 1'b1 : '0;
      if (acc_in) begin
        core_addr <= wr_addr;
        core_wdat <= in_data;
        count     <= wr_addr + 1'b1;
        run_cnt   <= run_cycles;
      end else if (state == RUN && run_cnt != '0)
        run_cnt <= run_cnt - 1'b1;
      if (acc_in && wr_addr == '1)
        load_full <= 1'b1;
      else if (acc_in && state == IDLE && !in_last)
        load_full <= 1'b0;
      // rid is presented RD_LAT cycles before rdata is captured for each index
      if (state != DUMP) begin
        core_rid <= '0;
        lat_cnt  <= '0;
      end else if (acc_out) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        core_rid  <= last_idx ? '0 : core_rid + 1'b1;
        lat_cnt   <= '0;
      end else if (!out_valid && lat_cnt == LW'(RD_LAT)) begin
        out_valid <= 1'b1;
        out_data  <= core_rdata;
        out_idx   <= core_rid;
        out_last  <= last_idx;
      end else if (!out_valid)
        lat_cnt <= lat_cnt + 1'b1;
    end
  end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Host-side sequencer that drives the processor's external program/debug interface (addr, wEn, wDat, working, rID, rdata) from the other end.
- Accepts a stream of 32-bit instruction words and writes them into instruction RAM at consecutive addresses from 0.
- Then asserts working for a programmed number of cycles and waits for the pipeline to drain.
- Finally reads r0..r(NREG-1) through rID/rdata and streams them out under valid/ready.

Parameters:
ADDR_W, 9, RAM word-address width; capacity 2**ADDR_W words
RUN_W, 16, width of run-cycle counter
DRAIN_CYCLES, 4, cycles with working low between RUN and register dump
RD_LAT, 1, clocks from rID change to valid rdata
NREG, 16, registers dumped (rID 0..NREG-1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  program word valid
in_ready  out  1  loader accepts program word
in_data  in  32  instruction word
in_last  in  1  final word of program
run_cycles  in  RUN_W  cycles to hold working high; sampled on last-word accept
core_addr  out  ADDR_W  RAM write address to processor
core_wen  out  1  RAM write enable to processor
core_wdat  out  32  RAM write data to processor
core_working  out  1  processor run enable
core_rid  out  4  register index to processor
core_rdata  in  32  register read data from processor
out_valid  out  1  register dump word valid
out_ready  in  1  downstream accepts dump word
out_data  out  32  register value
out_idx  out  4  register index of out_data
out_last  out  1  high with the final dump word (idx NREG-1)
busy  out  1  high in every state except IDLE
load_full  out  1  sticky; set when capacity forced end of load, cleared on next IDLE->LOAD
done  out  1  one-cycle pulse when dump completes

Behaviour:
- Reset (reset=0, async): state IDLE; every output 0 except in_ready=1. Word/run/drain/dump counters are 0. core_wen and core_working drop immediately, including mid-RUN or mid-write.
- Registered outputs: all core_* and out_* are registered. in_ready is decoded from state.
- Handshake: a transfer occurs on a clock edge where valid and ready are both 1.

States:
- IDLE: in_ready=1.
  - Accept -> LOAD, or RUN if in_last.
  - Accepted word is written at addr 0.
- LOAD: in_ready=1.
  - A word accepted at edge t makes core_wen=1, core_addr=count, core_wdat=in_data during cycle t+1. Count then increments.
  - core_wen=0 in cycles with no accept; in_valid gaps are allowed.
  - Accepting with in_last, or accepting the word at addr 2**ADDR_W-1 (sets load_full), -> RUN.
  - in_ready falls in the same cycle as the final core_wen pulse.
- RUN: core_working=1 for exactly run_cycles cycles, starting the cycle after the final core_wen pulse. It is never high together with core_wen.
  - run_cycles==0 -> go straight to DRAIN; core_working never rises.
- DRAIN: core_working=0 for DRAIN_CYCLES cycles -> DUMP.
- DUMP, per index i from 0 to NREG-1:
  - Drive core_rid=i and wait RD_LAT cycles.
  - Capture core_rdata into out_data, set out_idx=i and out_valid=1.
  - Hold out_data, out_idx and out_valid stable until out_ready.
  - On accept, out_valid=0 next cycle and i increments.
  - out_last=1 while i==NREG-1.
  - Accepting index NREG-1 -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- in_data is ignored outside IDLE/LOAD; in_ready=0 there.
- out_ready is ignored while out_valid=0.
- A new program always loads from address 0.

Test Plan:
- Load 3 words A1,B2,C3 (in_last on C3), run_cycles=10: core_wen pulses with addr 0/1/2 and data A1/B2/C3. core_working is high exactly 10 consecutive cycles, beginning the cycle after the addr-2 pulse. Drain is 4 cycles; then 16 dump words, idx 0..15, out_last on idx 15, done pulse, busy low after.
- Preload regfile model with r(i)=i*0x11 and hold out_ready low 3 cycles per word: out_data and out_idx hold stable while waiting. Values match 0x00..0xFF. Exactly 16 transfers occur.
- run_cycles=0 with a single-word program: core_working never asserts. DRAIN, then DUMP proceeds.
- ADDR_W=2, stream 6 words with no in_last: 4 writes at addr 0..3, load_full=1. in_ready=0 after the 4th accept; words 5 and 6 are not written.
- Drive in_valid with gaps (1 on, 2 off): core_wen pulses only after accepts, and addresses stay contiguous.
- Assert reset low mid-RUN at cycle 5 of 10: core_working=0 asynchronously. After release, state is IDLE with in_ready=1. The next program writes from addr 0.
